// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out on sd, holding each bit for BIT_CYCLES clocks.
module serial_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sd,
  output logic             sd_valid,
  output logic             frame,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [CW-1:0]    cyc_cnt, cyc_cnt_n;
  logic             in_ready_n, sd_n, sd_valid_n, frame_n, done_n;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    cyc_cnt_n = cyc_cnt;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_n   = S_SHIFT;
          shreg_n   = in_data;
          bit_cnt_n = '0;
          cyc_cnt_n = '0;
        end
      end
      S_SHIFT: begin
        if (cyc_cnt == LAST_CYC) begin
          cyc_cnt_n = '0;
          shreg_n   = advance(shreg);
          if (bit_cnt == LAST_BIT) begin
            state_n   = S_DONE;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          cyc_cnt_n = cyc_cnt + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state so that they leave the flops aligned with it.
    in_ready_n = (state_n == S_IDLE);
    sd_valid_n = (state_n == S_SHIFT);
    sd_n       = sd_valid_n & head_bit(shreg_n);
    frame_n    = sd_valid_n && (bit_cnt_n == '0);
    done_n     = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      in_ready <= 1'b1;
      sd       <= 1'b0;
      sd_valid <= 1'b0;
      frame    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      cyc_cnt  <= cyc_cnt_n;
      in_ready <= in_ready_n;
      sd       <= sd_n;
      sd_valid <= sd_valid_n;
      frame    <= frame_n;
      done     <= done_n;
    end
  end

  // The data register needs no reset: sd is gated by state until a word is loaded.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (MSB-first/1 cycle per bit and LSB-first/4 cycles
// per bit) driven by directed and random words and checked against spec timing.
module tb_serial_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [W-1:0] in_data;
  logic sel;

  logic iv0, iv1, rdy0, rdy1, sd0, sd1, sv0, sv1, fr0, fr1, dn0, dn1;
  logic rdy, sdo, sv, fr, dn;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign iv0 = (sel == 1'b0) ? in_valid : 1'b0;
  assign iv1 = (sel == 1'b1) ? in_valid : 1'b0;
  assign rdy = sel ? rdy1 : rdy0;
  assign sdo = sel ? sd1  : sd0;
  assign sv  = sel ? sv1  : sv0;
  assign fr  = sel ? fr1  : fr0;
  assign dn  = sel ? dn1  : dn0;

  serial_tx #(.WIDTH(W), .BIT_CYCLES(1), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_data(in_data),
    .in_ready(rdy0), .sd(sd0), .sd_valid(sv0), .frame(fr0), .done(dn0));

  serial_tx #(.WIDTH(W), .BIT_CYCLES(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_data(in_data),
    .in_ready(rdy1), .sd(sd1), .sd_valid(sv1), .frame(fr1), .done(dn1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"}, 32'(rdy), 32'd1);
    check({tag, ".sd"},       32'(sdo), 32'd0);
    check({tag, ".sd_valid"}, 32'(sv),  32'd0);
    check({tag, ".frame"},    32'(fr),  32'd0);
    check({tag, ".done"},     32'(dn),  32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
      check_idle("idle");
      tick();
    end
  endtask

  // Starts at cycle 0 (acceptance) and returns at the start of cycle N+2.
  // During busy cycles in_valid/in_data are driven with bv/bd (random if rnd).
  task automatic xmit(input logic [W-1:0] word, input logic bv, input logic [W-1:0] bd,
                      input bit rnd);
    int bc, n_tot, bitn;
    bit msb;
    logic expb;
    bc    = sel ? 4 : 1;
    msb   = sel ? 1'b0 : 1'b1;
    n_tot = W * bc;
    in_valid = 1'b1;
    in_data  = word;
    @(negedge clk);
    check("accept.in_ready", 32'(rdy), 32'd1);
    tick();
    for (int c = 1; c <= n_tot + 1; c++) begin
      in_valid = rnd ? 1'($urandom) : bv;
      in_data  = rnd ? W'($urandom) : bd;
      @(negedge clk);
      if (c <= n_tot) begin
        bitn = (c - 1) / bc;
        expb = msb ? word[W-1-bitn] : word[bitn];
        check("shift.sd",       32'(sdo), 32'(expb));
        check("shift.sd_valid", 32'(sv),  32'd1);
        check("shift.frame",    32'(fr),  32'(bitn == 0));
        check("shift.in_ready", 32'(rdy), 32'd0);
        check("shift.done",     32'(dn),  32'd0);
      end else begin
        check("done.done",     32'(dn),  32'd1);
        check("done.sd_valid", 32'(sv),  32'd0);
        check("done.sd",       32'(sdo), 32'd0);
        check("done.frame",    32'(fr),  32'd0);
        check("done.in_ready", 32'(rdy), 32'd0);
      end
      tick();
    end
  endtask

  initial begin
    sel      = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    // Reset with a word offered: nothing may start on either instance.
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      sel = 1'b0; check_idle("reset0");
      sel = 1'b1; check_idle("reset1");
      sel = 1'b0;
    end
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("post_reset");
    tick();
    idle(1);

    // Single word MSB-first, then in_ready back in cycle 10.
    xmit(8'hA5, 1'b0, 8'h00, 0);
    idle(2);

    // Back-to-back with in_valid held: second acceptance in cycle 10.
    xmit(8'hF0, 1'b1, 8'h0F, 0);
    xmit(8'h0F, 1'b0, 8'h00, 0);
    idle(1);

    // Busy-time changes on in_data are ignored.
    xmit(8'h3C, 1'b1, 8'hFF, 0);
    idle(1);

    // Reset in cycle 4 of a word aborts it with no done pulse.
    in_valid = 1'b1;
    in_data  = 8'h96;
    tick();
    for (int c = 1; c <= 4; c++) begin
      in_valid = 1'b0;
      reset    = (c == 4);
      @(negedge clk);
      check("abort.sd", 32'(sdo), 32'(8'h96 >> (W - c) & 1));
      tick();
    end
    reset = 1'b0;
    idle(12);
    xmit(8'h5A, 1'b0, 8'h00, 0);
    idle(1);

    // LSB-first, 4 cycles per bit.
    sel = 1'b1;
    idle(1);
    xmit(8'h01, 1'b0, 8'h00, 0);
    idle(1);
    xmit(8'hC3, 1'b1, 8'hFF, 0);
    idle(1);

    // Randomized words with random busy-time input activity on both instances.
    for (int k = 0; k < 12; k++) begin
      sel = k[0];
      idle(1);
      xmit(W'($urandom), 1'b0, 8'h00, 1);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out transmitter that turns a WIDTH-bit word into a timed single-bit stream on `sd`. It is the driving end of the serial bit line that our flip-flop and shift-register capture blocks sample. It replaces hand-written per-bit stimulus with a clocked, handshaked source usable both in RTL and in benches. Each bit is held for BIT_CYCLES clocks, with framing and completion strobes for the receiving side.

## Interface
- WIDTH, 8, bits per word (>= 2)
- BIT_CYCLES, 1, clocks each bit is held on `sd` (>= 1)
- MSB_FIRST, 1, 1 = transmit in_data[WIDTH-1] first, 0 = in_data[0] first

- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  word offered on in_data
- in_data  input  WIDTH  word to transmit
- in_ready  output  1  transmitter can accept a word
- sd  output  1  serial data bit
- sd_valid  output  1  `sd` carries a valid bit
- frame  output  1  high while the first bit of a word is on `sd`
- done  output  1  one-cycle pulse after the last bit of a word

## Operation
- All outputs are registered. The block has one clock and a synchronous, active-high `reset`.
- States and their outputs:
  - IDLE: in_ready=1, sd=0, sd_valid=0, frame=0, done=0.
  - SHIFT: in_ready=0, sd_valid=1, sd = current bit.
  - DONE: in_ready=0, sd_valid=0, sd=0, done=1.
- IDLE to SHIFT when in_valid && in_ready is sampled at a clock edge. At that edge:
  - the shift register loads in_data;
  - the bit counter clears to 0;
  - the cycle counter clears to 0.
- SHIFT behaviour:
  - The cycle counter increments each clock.
  - When it reaches BIT_CYCLES-1, it wraps to 0 and the register shifts to the next bit (left if MSB_FIRST, else right). The bit counter then increments.
  - When the bit counter = WIDTH-1 and the cycle counter = BIT_CYCLES-1, the next state is DONE.
- DONE to IDLE unconditionally after one cycle.
- Bit order:
  - MSB_FIRST=1: in_data[WIDTH-1] down to in_data[0].
  - MSB_FIRST=0: in_data[0] up to in_data[WIDTH-1].
- `frame` is 1 for exactly the BIT_CYCLES cycles of bit 0 of each word.
- in_data is sampled only at acceptance. Later changes on in_data have no effect.
- in_valid outside IDLE is ignored. There is no buffering.
- Counter widths:
  - bit counter: $clog2(WIDTH);
  - cycle counter: $clog2(BIT_CYCLES), minimum 1 bit.
  - Neither counter may overflow before its compare.
- Reset:
  - Values after the reset edge: IDLE, in_ready=1, sd=0, sd_valid=0, frame=0, done=0, counters=0.
  - Reset mid-word aborts the word. No done pulse follows, and no residual bits appear.
  - Reset dominates acceptance when in_valid and reset are both high.

## Timing
- Let cycle 0 be the cycle in which in_valid && in_ready is high at the closing edge.
- Bit n (0-based) is on `sd` during cycles 1 + n·BIT_CYCLES through (n+1)·BIT_CYCLES.
- sd_valid=1 for cycles 1 through WIDTH·BIT_CYCLES.
- done=1 in cycle WIDTH·BIT_CYCLES+1.
- in_ready=1 again from cycle WIDTH·BIT_CYCLES+2.
- Word period is WIDTH·BIT_CYCLES+2 cycles when in_valid is held high continuously.
- First-bit latency is 1 cycle after acceptance.
- `sd` is stable for all BIT_CYCLES clocks of a bit. It changes only on bit boundaries.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 and in_data=8'hFF.
  - Required: in_ready=1, sd=0, sd_valid=0, frame=0, done=0, and nothing is transmitted.
- Single word, WIDTH=8, BIT_CYCLES=1, MSB_FIRST=1: accept 8'hA5 in cycle 0.
  - Required: sd = 1,0,1,0,0,1,0,1 in cycles 1–8, frame=1 only in cycle 1, done=1 in cycle 9, in_ready=1 in cycle 10.
- Hold and LSB order, BIT_CYCLES=4, MSB_FIRST=0: accept 8'h01.
  - Required: sd=1 in cycles 1–4, sd=0 in cycles 5–32, frame=1 in cycles 1–4, done in cycle 33.
- Back-to-back, BIT_CYCLES=1: hold in_valid=1 with 8'hF0 then 8'h0F.
  - Required: second acceptance in cycle 10, its first bit in cycle 11, and no merging of the two words.
- Busy-time changes, BIT_CYCLES=1: accept 8'h3C, then drive in_data=8'hFF with in_valid=1 in cycles 2–8.
  - Required: the transmitted stream is still 0,0,1,1,1,1,0,0.
- Reset mid-word: assert reset in cycle 4 of a word.
  - Required: from cycle 5, sd_valid=0, done never pulses, and in_ready=1.
  - Required: a new word accepted afterwards transmits correctly.
